fifo_rr_scheduler: RTL and testbench

Write-side arbiter and read-side sequencer for the BRAM-backed `fifo` block. It shares one FIFO between `N_REQ` producers using round-robin valid/ready arbitration and tags each word with its source index. On the read side it issues `fifo_pop`, absorbs the one-cycle BRAM read latency and presents a registered valid/ready stream to a single consumer, sustaining one word per cycle.

---
 rtl/fifo_rr_scheduler.sv | 112 +++++++++++
 tb/tb_fifo_rr_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_scheduler.sv
// Round-robin write arbiter and latency-absorbing read sequencer for a shared BRAM FIFO.
// Producer words are tagged with their source index; the read side streams one word per cycle.
module fifo_rr_scheduler #(
    parameter int N_REQ    = 4,
    parameter int DATA_LEN = 8,
    parameter int ID_W     = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_LEN-1:0] req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      fifo_push,
    output logic [ID_W+DATA_LEN-1:0]  fifo_indata,
    input  logic                      fifo_full,
    input  logic                      fifo_empty,
    output logic                      fifo_pop,
    input  logic [ID_W+DATA_LEN-1:0]  fifo_outdata,
    output logic                      out_valid,
    output logic [DATA_LEN-1:0]       out_data,
    output logic [ID_W-1:0]           out_src,
    input  logic                      out_ready
);

    localparam int W = ID_W + DATA_LEN;

    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;
    logic [ID_W:0]       sum;
    logic [DATA_LEN-1:0] grant_data;

    logic [1:0]   occ;
    logic         inflight;
    logic [W-1:0] ob_head;
    logic [W-1:0] ob_tail;
    logic         retire;
    logic [2:0]   pend;

    // Walk candidates from the farthest offset down so the nearest one to rr_ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        sum       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ))
                sum = sum - (ID_W+1)'(N_REQ);
            if (req_valid[sum[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = sum[ID_W-1:0];
            end
        end
        grant_any = grant_any & rst_n & ~fifo_full;
    end

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_idx == ID_W'(k))
                grant_data = req_data[k*DATA_LEN +: DATA_LEN];
        end
    end

    assign req_ready   = grant_any ? (N_REQ'(1) << grant_idx) : '0;
    assign fifo_push   = grant_any;
    assign fifo_indata = {grant_idx, grant_data};

    // Counting the in-flight word reserves its buffer slot before it returns.
    assign retire    = out_valid & out_ready;
    assign pend      = {1'b0, occ} + {2'b00, inflight};
    assign fifo_pop  = rst_n & ~fifo_empty & (pend < (3'd2 + {2'b00, retire}));
    assign out_valid = (occ != 2'd0);
    assign {out_src, out_data} = ob_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            ob_head  <= '0;
            ob_tail  <= '0;
        end else begin
            inflight <= fifo_pop;
            if (fifo_push)
                rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            case ({inflight, retire})
                2'b10: begin
                    if (occ == 2'd0)
                        ob_head <= fifo_outdata;
                    else
                        ob_tail <= fifo_outdata;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    ob_head <= ob_tail;
                    occ     <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        ob_head <= fifo_outdata;
                    end else begin
                        ob_head <= ob_tail;
                        ob_tail <= fifo_outdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: an 8-deep FIFO model sits between write and read side,
// and a queue-based reference model predicts grants and the output word stream.
module tb_fifo_rr_scheduler;

    localparam int N     = 4;
    localparam int D     = 8;
    localparam int IW    = 2;
    localparam int W     = IW + D;
    localparam int DEPTH = 8;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*D-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             fifo_push;
    logic [W-1:0]     fifo_indata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [W-1:0]     fifo_outdata;
    logic             out_valid;
    logic [D-1:0]     out_data;
    logic [IW-1:0]    out_src;
    logic             out_ready;

    fifo_rr_scheduler #(.N_REQ(N), .DATA_LEN(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_push(fifo_push), .fifo_indata(fifo_indata),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_pop(fifo_pop), .fifo_outdata(fifo_outdata),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO environment: registered read data, the cycle after a pop.
    logic [W-1:0] fmem [DEPTH];
    int fcnt, frd, fwr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt <= 0; frd <= 0; fwr <= 0; fifo_outdata <= '0;
        end else begin
            if (fifo_push && fcnt < DEPTH) begin
                fmem[fwr] <= fifo_indata;
                fwr <= (fwr + 1) % DEPTH;
            end
            if (fifo_pop && fcnt > 0) begin
                fifo_outdata <= fmem[frd];
                frd <= (frd + 1) % DEPTH;
            end
            fcnt <= fcnt + ((fifo_push && fcnt < DEPTH) ? 1 : 0) - ((fifo_pop && fcnt > 0) ? 1 : 0);
        end
    end
    assign fifo_full  = (fcnt == DEPTH);
    assign fifo_empty = (fcnt == 0);

    int checks, errors;
    int cyc, m_ptr, first_push, first_valid, last_g;
    int pop_cnt, valid_cnt, full_cycles;
    int grant_bad, pop_bad, push_bad, indata_bad, stable_bad, full_ready_bad;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           glog[$];
    logic         stall_prev;
    logic [W-1:0] stall_word;

    function automatic int model_grant(logic [N-1:0] v, logic full, int ptr);
        if (full) return -1;
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic clear_logs();
        exp_q.delete(); got_q.delete(); glog.delete();
        cyc = 0; first_push = -1; first_valid = -1; last_g = -1;
        pop_cnt = 0; valid_cnt = 0; full_cycles = 0;
        grant_bad = 0; pop_bad = 0; push_bad = 0; indata_bad = 0; stable_bad = 0; full_ready_bad = 0;
        stall_prev = 1'b0; stall_word = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req_valid = '0; out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; m_ptr = 0;
        clear_logs();
    endtask

    // One clock of reference-model bookkeeping; inputs are already driven.
    task automatic step();
        int g;
        logic [W-1:0] w;
        logic [N-1:0] exp_r;
        #1;
        g = model_grant(req_valid, fifo_full, m_ptr);
        exp_r = '0;
        if (g >= 0) begin
            w = {g[IW-1:0], req_data[g*D +: D]};
            exp_r = N'(1) << g;
            exp_q.push_back(w);
            glog.push_back(g);
            m_ptr = (g + 1) % N;
            if (first_push < 0) first_push = cyc;
            if (fifo_indata !== w) indata_bad++;
        end
        if (req_ready !== exp_r) grant_bad++;
        if (fifo_full) begin
            full_cycles++;
            if (req_ready !== '0) full_ready_bad++;
        end
        if (fifo_pop === 1'b1 && fifo_empty) pop_bad++;
        if (fifo_push === 1'b1 && fifo_full) push_bad++;
        if (fifo_pop === 1'b1) pop_cnt++;
        if (out_valid === 1'b1) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (stall_prev && (out_valid !== 1'b1 || {out_src, out_data} !== stall_word)) stable_bad++;
        stall_prev = out_valid & ~out_ready;
        stall_word = {out_src, out_data};
        if (out_valid && out_ready) got_q.push_back({out_src, out_data});
        last_g = g;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '1; req_data = $urandom; out_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL reset_push got=%b exp=0", fifo_push); end
        checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop got=%b exp=0", fifo_pop); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if ({out_src, out_data} !== '0) begin errors++; $display("FAIL reset_out_word got=%h exp=0", {out_src, out_data}); end
        rst_n = 1'b1; m_ptr = 0; clear_logs();
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int cnt[N];
        logic mm;
        apply_reset();
        foreach (cnt[i]) cnt[i] = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            req_valid = '1;
            for (int i = 0; i < N; i++) req_data[i*D +: D] = D'(16 * i + cnt[i]);
            step();
            if (last_g >= 0) cnt[last_g]++;
        end
        req_valid = '0;
        for (int c = 0; c < 60 && got_q.size() < exp_q.size(); c++) step();
        checks++; mm = (glog.size() < 8);
        for (int k = 0; k < 8 && !mm; k++) if (glog[k] != k % N) mm = 1;
        if (mm) begin errors++; $display("FAIL rr_grant_order first grants not 0,1,2,3,0,1,2,3 (got %0d grants)", glog.size()); end
        checks++; if (first_valid - first_push != 3) begin errors++; $display("FAIL rr_latency got=%0d exp=3", first_valid - first_push); end
        checks++; if (grant_bad != 0 || indata_bad != 0) begin errors++; $display("FAIL rr_grant_model grant_bad=%0d indata_bad=%0d exp=0", grant_bad, indata_bad); end
        checks++; mm = (got_q.size() != exp_q.size());
        for (int k = 0; k < got_q.size() && !mm; k++) if (got_q[k] !== exp_q[k] || int'(got_q[k][W-1:D]) != glog[k]) mm = 1;
        if (mm) begin errors++; $display("FAIL rr_stream got %0d words exp %0d words or order/src differs", got_q.size(), exp_q.size()); end
        checks++; if (valid_cnt != 20) begin errors++; $display("FAIL rr_throughput out_valid cycles got=%0d exp=20", valid_cnt); end
    endtask

    task automatic test_fairness();
        int exp_f[4];
        int base;
        logic mm;
        exp_f = '{3, 1, 3, 1};
        apply_reset();
        out_ready = 1'b1;
        req_valid = 4'b0010; req_data = $urandom; step();
        base = glog.size();
        for (int c = 0; c < 4; c++) begin
            req_valid = 4'b1010; req_data = $urandom; step();
        end
        for (int c = 0; c < 2; c++) begin
            req_valid = 4'b1011; req_data = $urandom; step();
        end
        req_valid = '0;
        for (int c = 0; c < 40 && got_q.size() < exp_q.size(); c++) step();
        checks++; mm = (glog.size() < base + 6);
        for (int k = 0; k < 4 && !mm; k++) if (glog[base + k] != exp_f[k]) mm = 1;
        if (mm) begin errors++; $display("FAIL fair_order grants after ptr=2 not 3,1,3,1 (got %0d grants)", glog.size()); end
        checks++; if (glog.size() < base + 6 || (glog[base + 4] != 0 && glog[base + 5] != 0)) begin
            errors++; $display("FAIL fair_late_req0 requester 0 not granted within 2 pushes");
        end
        checks++; if (grant_bad != 0) begin errors++; $display("FAIL fair_grant_model grant_bad=%0d exp=0", grant_bad); end
        checks++; mm = (got_q.size() != exp_q.size());
        for (int k = 0; k < got_q.size() && !mm; k++) if (got_q[k] !== exp_q[k]) mm = 1;
        if (mm) begin errors++; $display("FAIL fair_stream got %0d words exp %0d words or order differs", got_q.size(), exp_q.size()); end
    endtask

    task automatic test_full_backpressure();
        int sent, steps;
        logic mm;
        apply_reset();
        out_ready = 1'b0; sent = 0;
        for (int c = 0; c < 30; c++) begin
            req_valid = (sent < 12) ? 4'b0100 : 4'b0000;
            req_data = '0; req_data[2*D +: D] = D'(sent);
            step();
            if (last_g == 2) sent++;
        end
        checks++; if (sent != 10) begin errors++; $display("FAIL full_accepted got=%0d exp=10", sent); end
        checks++; if (full_cycles == 0 || full_ready_bad != 0) begin errors++; $display("FAIL full_ready full_cycles=%0d ready_while_full=%0d", full_cycles, full_ready_bad); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL full_no_output got=%0d exp=0", got_q.size()); end
        out_ready = 1'b1; steps = 0;
        for (int c = 0; c < 40 && got_q.size() < 12; c++) begin
            req_valid = (sent < 12) ? 4'b0100 : 4'b0000;
            req_data = '0; req_data[2*D +: D] = D'(sent);
            step();
            steps++;
            if (last_g == 2) sent++;
        end
        checks++; if (steps != 12) begin errors++; $display("FAIL full_drain_gapless cycles got=%0d exp=12", steps); end
        checks++; mm = (got_q.size() != 12 || exp_q.size() != 12);
        for (int k = 0; k < got_q.size() && !mm; k++) if (got_q[k] !== exp_q[k] || got_q[k] !== {2'd2, D'(k)}) mm = 1;
        if (mm) begin errors++; $display("FAIL full_stream got %0d words exp 12 in order", got_q.size()); end
        checks++; if (stable_bad != 0 || push_bad != 0) begin errors++; $display("FAIL full_stall_stable stable_bad=%0d push_bad=%0d exp=0", stable_bad, push_bad); end
    endtask

    task automatic test_single_word();
        int who;
        apply_reset();
        out_ready = 1'b1;
        who = $urandom_range(0, N - 1);
        req_valid = N'(1) << who; req_data = $urandom; step();
        req_valid = '0;
        for (int c = 0; c < 10; c++) step();
        checks++; if (pop_cnt != 1) begin errors++; $display("FAIL single_pop_count got=%0d exp=1", pop_cnt); end
        checks++; if (valid_cnt != 1) begin errors++; $display("FAIL single_valid_cycles got=%0d exp=1", valid_cnt); end
        checks++; if (pop_bad != 0) begin errors++; $display("FAIL single_pop_when_empty got=%0d exp=0", pop_bad); end
        checks++; if (first_valid - first_push != 3) begin errors++; $display("FAIL single_latency got=%0d exp=3", first_valid - first_push); end
        checks++; if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL single_word got %0d words exp 1 matching", got_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w0;
        apply_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            req_valid = 4'b0010; req_data = $urandom; step();
        end
        req_valid = '0; out_ready = 1'b1; step();
        w0 = exp_q[0];
        checks++; if (got_q.size() != 1 || got_q[0] !== w0) begin errors++; $display("FAIL mid_pre_word got %0d words exp 1 matching", got_q.size()); end
        req_valid = 4'b0010;
        rst_n = 1'b0; #1;
        checks++; if (out_valid !== 1'b0 || req_ready !== '0 || fifo_pop !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs valid=%b ready=%b pop=%b exp all 0", out_valid, req_ready, fifo_pop);
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1; m_ptr = 0; clear_logs();
        for (int c = 0; c < 6; c++) step();
        checks++; if (valid_cnt != 0 || pop_cnt != 0) begin errors++; $display("FAIL mid_stale valid_cycles=%0d pops=%0d exp 0", valid_cnt, pop_cnt); end
        req_valid = 4'b1000; req_data = $urandom; step();
        req_valid = '0;
        for (int c = 0; c < 6; c++) step();
        checks++; if (first_valid - first_push != 3) begin errors++; $display("FAIL mid_new_latency got=%0d exp=3", first_valid - first_push); end
        checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin errors++; $display("FAIL mid_new_word got %0d words exp 1 matching", got_q.size()); end
    endtask

    task automatic test_random();
        logic mm;
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            req_valid = N'($urandom);
            req_data  = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        req_valid = '0; out_ready = 1'b1;
        for (int c = 0; c < 100 && got_q.size() < exp_q.size(); c++) step();
        checks++; mm = (got_q.size() != exp_q.size());
        for (int k = 0; k < got_q.size() && !mm; k++) if (got_q[k] !== exp_q[k]) mm = 1;
        if (mm) begin errors++; $display("FAIL rand_stream got %0d words exp %0d words or order differs", got_q.size(), exp_q.size()); end
        checks++; if (grant_bad != 0 || indata_bad != 0) begin errors++; $display("FAIL rand_grant grant_bad=%0d indata_bad=%0d exp=0", grant_bad, indata_bad); end
        checks++; if (pop_bad != 0 || push_bad != 0) begin errors++; $display("FAIL rand_flags pop_when_empty=%0d push_when_full=%0d exp=0", pop_bad, push_bad); end
        checks++; if (stable_bad != 0) begin errors++; $display("FAIL rand_stall_stable got=%0d exp=0", stable_bad); end
    endtask

    initial begin
        checks = 0; errors = 0; m_ptr = 0;
        rst_n = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
        clear_logs();
        #1;
        test_reset();
        test_round_robin();
        test_fairness();
        test_full_backpressure();
        test_single_word();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
